// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - SPI master FSM state type and mode-0 constants shared with the slave side.
package spi_pkg;

  localparam int   SPI_BYTE_W    = 8;
  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_CPHA      = 1'b0;
  localparam logic SPI_MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_GAP
  } spi_master_st_t;

  function automatic int sel_width(input int nslaves);
    return (nslaves > 1) ? $clog2(nslaves) : 1;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host start/busy handshake plus SPI bus wires of spi_master.
interface spi_master_if #(
  parameter int NSLAVES = 4
);
  import spi_pkg::*;

  localparam int SEL_W = sel_width(NSLAVES);

  logic                  start_i;
  logic [SEL_W-1:0]      sel_i;
  logic [SPI_BYTE_W-1:0] tx_data_i;
  logic                  keep_ss_i;
  logic                  busy_o;
  logic [SPI_BYTE_W-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  sck_o;
  logic                  mosi_o;
  logic                  miso_i;
  logic [NSLAVES-1:0]    ss_o;

  modport master (
    input  start_i, sel_i, tx_data_i, keep_ss_i, miso_i,
    output busy_o, rx_data_o, rx_valid_o, sck_o, mosi_o, ss_o
  );

  modport slave (
    output start_i, sel_i, tx_data_i, keep_ss_i, miso_i,
    input  busy_o, rx_data_o, rx_valid_o, sck_o, mosi_o, ss_o
  );

endinterface

// File: rtl/spi_half_tick.sv
// rtl/spi_half_tick.sv - HALF-cycle down-counter; tick_o marks the last cycle of a half-period.
module spi_half_tick #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW     = $clog2(HALF);
  localparam logic [CW-1:0] RELOAD = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (clr_i || (cnt_q == '0)) cnt_d = RELOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte mode-0 SPI master, MSB first, one-hot active-high selects.
// Optional SPI_MASTER_MISO_SYNC_EN: 2-flop miso synchroniser, each sample taken 2 cycles after sck rise.
module spi_master
  import spi_pkg::*;
#(
  parameter int NSLAVES = 4,
  parameter int HALF    = 4,
  parameter int GAP     = 8
) (
  input logic           Clk_i,
  input logic           Rst_ni,
  spi_master_if.master  bus
);

  localparam int SEL_W = sel_width(NSLAVES);
  localparam int BW    = $clog2(SPI_BYTE_W + 1);
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

  spi_master_st_t        state_q, state_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic [NSLAVES-1:0]    ss_q, ss_d;
  logic                  busy_q, busy_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [SPI_BYTE_W-1:0] shift_q, shift_d;
  logic [BW-1:0]         bitcnt_q, bitcnt_d;
  logic                  keep_q, keep_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;

  logic tick, rise, cap, miso_smp, sel_ok;

  spi_half_tick #(.HALF(HALF)) u_half_tick (
    .clk    (Clk_i),
    .rst_n  (Rst_ni),
    .clr_i  (state_d != state_q),
    .tick_o (tick)
  );

  assign rise   = tick && ((state_q == ST_SETUP) || (state_q == ST_SCK_LO));
  assign sel_ok = ({1'b0, bus.sel_i} < (SEL_W + 1)'(NSLAVES));

`ifdef SPI_MASTER_MISO_SYNC_EN
  // Capture is delayed to line up with the synchroniser output for the same sck rise.
  logic       miso_s1_q, miso_s2_q;
  logic [1:0] cap_dly_q;

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
      cap_dly_q <= '0;
    end else begin
      miso_s1_q <= bus.miso_i;
      miso_s2_q <= miso_s1_q;
      cap_dly_q <= {cap_dly_q[0], rise};
    end
  end

  assign cap      = cap_dly_q[1];
  assign miso_smp = miso_s2_q;
`else
  assign cap      = rise;
  assign miso_smp = bus.miso_i;
`endif

  always_comb begin
    state_d    = state_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    keep_d     = keep_q;
    gap_cnt_d  = gap_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i && sel_ok) begin
          shift_d  = bus.tx_data_i;
          keep_d   = bus.keep_ss_i;
          bitcnt_d = '0;
          mosi_d   = bus.tx_data_i[SPI_BYTE_W-1];
          busy_d   = 1'b1;
          for (int i = 0; i < NSLAVES; i++) ss_d[i] = (bus.sel_i == SEL_W'(i));
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP, ST_SCK_LO: begin
        if (tick) begin
          sck_d   = 1'b1;
          state_d = ST_SCK_HI;
        end
      end
      ST_SCK_HI: begin
        if (tick) begin
          sck_d    = SPI_CPOL;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_d == BW'(SPI_BYTE_W)) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            mosi_d     = 1'b0;
            if (!keep_q) ss_d = '0;
            gap_cnt_d  = GW'(GAP - 1);
            state_d    = ST_GAP;
          end else begin
            mosi_d  = shift_q[SPI_BYTE_W-1];
            state_d = ST_SCK_LO;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cap) shift_d = {shift_q[SPI_BYTE_W-2:0], miso_smp};
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state_q    <= ST_IDLE;
      sck_q      <= SPI_CPOL;
      mosi_q     <= 1'b0;
      ss_q       <= '0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      keep_q     <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      keep_q     <= keep_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign bus.sck_o      = sck_q;
  assign bus.mosi_o     = mosi_q;
  assign bus.ss_o       = ss_q;
  assign bus.busy_o     = busy_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with loopback and behavioural mode-0 slave.
module tb_spi_master;

  localparam int NSLAVES = 3;
  localparam int HALF    = 4;
  localparam int GAP     = 2;
  localparam int LAT     = 1 + 16 * HALF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if #(.NSLAVES(NSLAVES)) bus ();

  spi_master #(.NSLAVES(NSLAVES), .HALF(HALF), .GAP(GAP)) dut (
    .Clk_i  (clk),
    .Rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Behavioural mode-0 slave on select 0, oversampling the bus on the falling clk edge.
  logic       loop_mode = 1'b1;
  logic [7:0] slv_tx = 8'h3C;
  logic [7:0] slv_sh = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  logic       slv_ss_q = 1'b0;
  logic       slv_sck_q = 1'b0;

  assign bus.miso_i = loop_mode ? bus.mosi_o : slv_sh[7];

  always @(negedge clk) begin
    slv_ss_q  <= bus.ss_o[0];
    slv_sck_q <= bus.sck_o;
    if (bus.ss_o[0] && !slv_ss_q) slv_sh <= slv_tx;
    else if (bus.ss_o[0] && slv_sck_q && !bus.sck_o) slv_sh <= {slv_sh[6:0], 1'b0};
    if (bus.ss_o[0] && !slv_sck_q && bus.sck_o) slv_rx <= {slv_rx[6:0], bus.mosi_o};
  end

  int   sck_rises = 0, sck_edges = 0, rxv_count = 0, last_rxv_cyc = 0;
  int   hi_run = 0, mosi_stab = 0, watch_idx = 0;
  logic prev_sck = 1'b0, prev_mosi = 1'b0, watch_ss = 1'b0, ss_drop = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sck_o != prev_sck) sck_edges <= sck_edges + 1;
      if (bus.sck_o && !prev_sck) begin
        sck_rises <= sck_rises + 1;
        check("mosi_setup", {31'd0, (bus.mosi_o == prev_mosi) && (mosi_stab >= HALF)}, 32'd1);
      end
      if (!bus.sck_o && prev_sck) check("sck_high_width", hi_run, HALF);
      if (bus.rx_valid_o) begin
        rxv_count    <= rxv_count + 1;
        last_rxv_cyc <= cyc;
        if (exp_q.size() == 0) begin
          check("rx_unexpected", exp_q.size(), 1);
        end else begin
          check("rx_data", bus.rx_data_o, exp_q[0].data);
          check("rx_latency", cyc, exp_q[0].cyc);
          exp_q.delete(0);
        end
      end
      if (watch_ss && !bus.ss_o[watch_idx]) ss_drop <= 1'b1;
    end
    hi_run    <= bus.sck_o ? hi_run + 1 : 0;
    mosi_stab <= (bus.mosi_o != prev_mosi) ? 1 : mosi_stab + 1;
    prev_sck  <= bus.sck_o;
    prev_mosi <= bus.mosi_o;
  end

  // Called on a falling clk edge; start_i is held for exactly one rising edge.
  task automatic start_xfer(input logic [1:0] sel, input logic [7:0] tx, input logic keep,
                            input logic accept);
    exp_t ex;
    bus.start_i   = 1'b1;
    bus.sel_i     = sel;
    bus.tx_data_i = tx;
    bus.keep_ss_i = keep;
    if (accept) begin
      ex.data = loop_mode ? tx : slv_tx;
      ex.cyc  = cyc + LAT;
      exp_q.push_back(ex);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    t = -1;
    for (int i = 0; i < 400 && t < 0; i++) begin
      @(negedge clk);
      if (!bus.busy_o) t = cyc;
    end
    if (t < 0) check("idle_timeout", {31'd0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, base, rv;
    bus.start_i   = 1'b0;
    bus.sel_i     = '0;
    bus.tx_data_i = '0;
    bus.keep_ss_i = 1'b0;
    #1;
    check("rst_sck", bus.sck_o, 0);
    check("rst_mosi", bus.mosi_o, 0);
    check("rst_ss", bus.ss_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_rx_valid", bus.rx_valid_o, 0);
    check("rst_rx_data", bus.rx_data_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Loopback byte to slave 2.
    base = sck_rises;
    start_xfer(2'd2, 8'hA5, 1'b0, 1'b1);
    check("ss_sel2", bus.ss_o, 3'b100);
    check("busy_set", bus.busy_o, 1);
    wait_idle(t);
    check("sck_count_a5", sck_rises - base, 8);
    check("busy_gap", t - last_rxv_cyc, GAP);
    check("ss_released", bus.ss_o, 0);
    check("mosi_idle", bus.mosi_o, 0);

    // Behavioural slave at index 0 returns 0x3C while receiving 0xFF.
    @(negedge clk);
    loop_mode = 1'b0;
    slv_tx    = 8'h3C;
    start_xfer(2'd0, 8'hFF, 1'b0, 1'b1);
    wait_idle(t);
    check("slave_rx", slv_rx, 8'hFF);
    loop_mode = 1'b1;

    // keep_ss burst on slave 1; second byte issued the cycle busy falls.
    @(negedge clk);
    rv = rxv_count;
    start_xfer(2'd1, 8'h5A, 1'b1, 1'b1);
    watch_idx = 1;
    watch_ss  = 1'b1;
    wait_idle(t);
    check("ss_held_idle", bus.ss_o, 3'b010);
    base = sck_rises;
    start_xfer(2'd1, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 400 && (sck_rises - base) < 8; i++) begin
      @(negedge clk);
      #1;
    end
    watch_ss = 1'b0;
    check("burst_rises", sck_rises - base, 8);
    wait_idle(t);
    check("burst_no_drop", ss_drop, 0);
    check("burst_two_rx", rxv_count - rv, 2);
    check("burst_ss_off", bus.ss_o, 0);

    // Back-to-back on slave 0, second start in the busy-fall cycle.
    @(negedge clk);
    start_xfer(2'd0, 8'hC3, 1'b0, 1'b1);
    wait_idle(t);
    start_xfer(2'd0, 8'h96, 1'b0, 1'b1);
    check("b2b_accepted", bus.busy_o, 1);
    wait_idle(t);

    // Mid-transfer start and out-of-range select are both ignored.
    @(negedge clk);
    base = sck_rises;
    start_xfer(2'd1, 8'h81, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    start_xfer(2'd0, 8'h00, 1'b0, 1'b0);
    check("ss_unchanged", bus.ss_o, 3'b010);
    wait_idle(t);
    check("sck_count_ign", sck_rises - base, 8);
    @(negedge clk);
    start_xfer(2'd3, 8'h55, 1'b0, 1'b0);
    check("badsel_busy", bus.busy_o, 0);
    check("badsel_ss", bus.ss_o, 0);
    repeat (3) @(negedge clk);
    check("badsel_still_idle", bus.busy_o, 0);

    // Asynchronous reset at the third sck edge of a transfer.
    @(negedge clk);
    base = sck_edges;
    rv   = rxv_count;
    start_xfer(2'd2, 8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 200 && (sck_edges - base) < 3; i++) begin
      @(negedge clk);
      #1;
    end
    check("rst_at_3rd_edge", sck_edges - base, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sck", bus.sck_o, 0);
    check("mid_rst_mosi", bus.mosi_o, 0);
    check("mid_rst_ss", bus.ss_o, 0);
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_rx_valid", bus.rx_valid_o, 0);
    check("mid_rst_rx_data", bus.rx_data_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("no_rx_after_reset", rxv_count - rv, 0);
    check("busy_after_reset", bus.busy_o, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI bus master, mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits directly upstream of the slave instances on the shared SPI bus: drives sck, mosi and the per-slave active-high selects, and captures miso.
- A host-side start/busy handshake launches one 8-bit full-duplex transfer to a chosen slave.
- Timing is sized for slaves that oversample sck and mosi through 2-flop synchronisers on the same Clk_i.

Parameters:
- NSLAVES, 4, number of slave select lines (>=1).
- HALF, 4, Clk_i cycles per sck half-period; also the ss-to-first-edge setup time. Legal range >=4.
- GAP, 8, Clk_i cycles of idle after each byte before busy_o drops. Legal range >=2.

Ports:
- Clk_i  input  1  system clock; all logic on its rising edge.
- Rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  single-cycle request; sampled only when busy_o=0.
- sel_i  input  $clog2(NSLAVES) (min 1)  target slave index; latched with start_i.
- tx_data_i  input  8  byte to transmit; latched with start_i.
- keep_ss_i  input  1  1 = keep select asserted after this byte (burst); latched with start_i.
- busy_o  output  1  high from the cycle after an accepted start_i until GAP expires.
- rx_data_o  output  8  last received byte; holds until the next completion.
- rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
- sck_o  output  1  SPI clock.
- mosi_o  output  1  serial data out.
- miso_i  input  1  serial data in.
- ss_o  output  NSLAVES  one-hot active-high selects.

Behaviour:
- Reset, asynchronous: sck_o=0, mosi_o=0, ss_o=0, busy_o=0, rx_valid_o=0, rx_data_o=0, state IDLE, counters 0. Reset mid-transfer aborts immediately with no rx_valid_o.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, GAP. One half-period counter runs 0..HALF-1; one bit counter runs 0..8.
- IDLE:
  - start_i=1 and sel_i<NSLAVES: latch tx_data_i into shift reg, sel, keep_ss; next cycle ss_o[sel]=1, mosi_o=tx[7], busy_o=1; go SETUP.
  - start_i with sel_i>=NSLAVES: ignored (no busy, no ss).
  - start_i while busy_o=1: ignored.
- SETUP: after HALF cycles, sck_o rises, miso sampled into shift reg LSB; go SCK_HI.
- SCK_HI: after HALF cycles, sck_o falls and bitcnt increments.
  - bitcnt reaches 8: go GAP.
  - Otherwise: mosi_o presents next bit (shift reg MSB after left shift); go SCK_LO.
- SCK_LO: after HALF cycles, sck_o rises, sample miso; go SCK_HI.
- mosi_o changes only at sck falling edges (and at select), so it is stable >=HALF cycles before every rising edge.
- Completion:
  - On entry to GAP: rx_data_o <= captured byte, rx_valid_o=1 for exactly one cycle.
  - ss_o drops to 0 unless keep_ss latched 1.
  - mosi_o returns to 0; sck_o stays 0.
- GAP:
  - Hold GAP cycles, then busy_o=0 and go IDLE.
  - Latency from accepted start_i to rx_valid_o: 1 + HALF*(1+2*8-1) = 1+16*HALF cycles (65 at HALF=4).
- keep_ss burst: a following start_i to the same sel keeps ss_o asserted continuously.
  - A following start_i to a different sel drops the old select in the same cycle the new one rises.
  - An idle master never holds more than one ss bit.
- bitcnt wraps to 0 on each new start. The shift reg is 8 bits; no partial-byte output.

Optional Feature:
- Macro: SPI_MASTER_MISO_SYNC_EN.
- Defined: miso_i passes through a 2-flop synchroniser, and each sample is taken 2 cycles after the corresponding sck rise. The captured bit equals miso at the rising edge. Requires HALF>=4; latency to rx_valid_o unchanged.
- Undefined: miso_i is sampled directly in the cycle sck_o rises.

Decomposition:
- Package spi_pkg:
  - spi_master_st_t enum (IDLE, SETUP, SCK_HI, SCK_LO, GAP)
  - SPI_BYTE_W=8
  - shared SPI mode constants, reusable by the slave side.
- Sub-module spi_half_tick: the HALF-cycle down-counter emitting a one-cycle tick; cleared on state change.

Test Plan:
- Reset with a transfer in flight (assert Rst_ni=0 at the 3rd sck edge) -> all outputs 0 at once, no rx_valid_o, busy_o=0.
- start_i, sel_i=2, tx=0xA5, miso looped to mosi -> ss_o=4'b0100, exactly 8 sck pulses each 2*HALF wide, rx_data_o=0xA5 with rx_valid_o 65 cycles after start, busy_o low GAP cycles later.
- Behavioural mode-0 slave at index 0 returning 0x3C, tx=0xFF -> rx_data_o=0x3C; slave receives 0xFF. Run with and without SPI_MASTER_MISO_SYNC_EN.
- keep_ss_i=1 then second start_i, same sel, tx=0x01 -> ss_o[sel] never deasserts between bytes; two rx_valid_o pulses.
- start_i pulsed mid-transfer, and start_i with sel_i=NSLAVES -> both ignored; tx byte and sck count unchanged.
- HALF=4, GAP=2 back-to-back starts issued the cycle busy_o falls -> each accepted; mosi stable >=4 cycles before every sck rise (assertion).
